frm_vote_buffer: RTL and testbench

Frame-level brightness classifier with multi-frame voting and hysteresis. It is the parametrised successor of the single-frame, fixed-threshold frame buffer. It counts bright pixels over each frame, classifies the frame as bright or dark, keeps a sliding window of the last HIST verdicts, and drives a hysteretic invert request `rx_o` to the dark-mode inversion path. It generalises pixel width and channel count, makes thresholds runtime-programmable, and removes single-frame flicker.

---
 rtl/frm_vote_buffer.sv | 104 ++++++++++
 tb/tb_frm_vote_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frm_vote_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : frm_vote_buffer
//  Summary  : Per-frame bright-pixel classifier with a HIST-frame majority
//             window and hysteretic invert request.
//  Revision : 1.0  initial release
// ============================================================================
module frm_vote_buffer #(
  parameter int CH     = 3,
  parameter int W      = 8,
  parameter int CNT_W  = 22,
  parameter int HIST   = 8,
  parameter int ON_TH  = 6,
  parameter int OFF_TH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       vs_i,
  input  logic                       de_i,
  input  logic [CH*W-1:0]            wd_i,
  input  logic [W-1:0]               px_th_i,
  input  logic [CNT_W-1:0]           frm_th_i,
  output logic                       rx_o,
  output logic [$clog2(HIST+1)-1:0]  votes_o,
  output logic                       frm_valid_o
);

  localparam int             c_vw      = $clog2(HIST+1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic              r_vs;
  logic              r_arm;
  logic [CNT_W-1:0]  r_cnt;
  logic [HIST-1:0]   r_hist;
  logic [c_vw-1:0]   r_votes;
  logic              r_rx;
  logic              r_frm_valid;

  logic              w_bright;
  logic              w_edge;
  logic              w_verdict;
  logic              w_commit;
  logic [HIST-1:0]   w_hist_next;
  logic [c_vw-1:0]   w_votes_next;

  always_comb begin
    w_bright = 1'b0;
    if (de_i) begin
      for (int c = 0; c < CH; c++) begin
        if (wd_i[c*W +: W] > px_th_i) w_bright = 1'b1;
      end
    end
  end

  assign w_edge    = r_vs & ~vs_i;
  assign w_verdict = (r_cnt >= frm_th_i);
  // The first edge after reset closes a partial frame, so only armed edges commit.
  assign w_commit  = w_edge & r_arm;

  always_comb begin
    w_hist_next    = r_hist << 1;
    w_hist_next[0] = w_verdict;
    w_votes_next   = r_votes + c_vw'(w_verdict) - c_vw'(r_hist[HIST-1]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vs        <= 1'b0;
      r_arm       <= 1'b0;
      r_cnt       <= '0;
      r_hist      <= '0;
      r_votes     <= '0;
      r_rx        <= 1'b0;
      r_frm_valid <= 1'b0;
    end else begin
      r_vs        <= vs_i;
      r_frm_valid <= w_commit;

      // The edge-cycle pixel already belongs to the new frame.
      if (w_edge) begin
        r_cnt <= CNT_W'(w_bright);
        r_arm <= 1'b1;
      end else if (w_bright && (r_cnt != c_cnt_max)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_commit) begin
        r_hist  <= w_hist_next;
        r_votes <= w_votes_next;
        if (w_votes_next >= c_vw'(ON_TH)) begin
          r_rx <= 1'b1;
        end else if (w_votes_next <= c_vw'(OFF_TH)) begin
          r_rx <= 1'b0;
        end
      end
    end
  end

  assign rx_o        = r_rx;
  assign votes_o     = r_votes;
  assign frm_valid_o = r_frm_valid;

endmodule
`default_nettype wire

// File: tb/tb_frm_vote_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frm_vote_buffer
//  Summary  : Frame-table, corner-sequence and randomized checks of
//             frm_vote_buffer against a frame-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frm_vote_buffer;

  localparam int HIST   = 8;
  localparam int ON_TH  = 6;
  localparam int OFF_TH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        vs, de;
  logic [23:0] wd;
  logic [7:0]  px_th;
  logic [21:0] frm_th;
  logic [3:0]  frm_th4;
  logic        rx0, rx4, fv0, fv4;
  logic [3:0]  votes0, votes4;

  always #5 clk = ~clk;

  frm_vote_buffer #(.CH(3), .W(8), .CNT_W(22), .HIST(HIST), .ON_TH(ON_TH), .OFF_TH(OFF_TH)) dut (
    .clk_i(clk), .rst_i(rst), .vs_i(vs), .de_i(de), .wd_i(wd), .px_th_i(px_th),
    .frm_th_i(frm_th), .rx_o(rx0), .votes_o(votes0), .frm_valid_o(fv0)
  );

  frm_vote_buffer #(.CH(3), .W(8), .CNT_W(4), .HIST(HIST), .ON_TH(ON_TH), .OFF_TH(OFF_TH)) dut4 (
    .clk_i(clk), .rst_i(rst), .vs_i(vs), .de_i(de), .wd_i(wd), .px_th_i(px_th),
    .frm_th_i(frm_th4), .rx_o(rx4), .votes_o(votes4), .frm_valid_o(fv4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-frame pixel tally and a queue of recent verdicts.
  bit     m_vsr, m_arm, m_valid;
  longint m_cnt;
  bit     q0[$];
  bit     q1[$];
  int     m_votes0, m_votes4;
  bit     m_rx0, m_rx4;

  function automatic bit px_bright(input logic d, input logic [23:0] w, input logic [7:0] th);
    bit b = 1'b0;
    if (d) for (int c = 0; c < 3; c++) if (w[c*8 +: 8] > th) b = 1'b1;
    return b;
  endfunction

  function automatic bit rx_next(input int votes, input bit rx);
    if (votes >= ON_TH) return 1'b1;
    if (votes <= OFF_TH) return 1'b0;
    return rx;
  endfunction

  task automatic model_update();
    bit b, v0, v1;
    longint sat0, sat4;
    if (rst) begin
      m_vsr = 0; m_arm = 0; m_valid = 0; m_cnt = 0;
      q0.delete(); q1.delete();
      m_votes0 = 0; m_votes4 = 0; m_rx0 = 0; m_rx4 = 0;
    end else begin
      b = px_bright(de, wd, px_th);
      m_valid = 0;
      if (m_vsr && !vs) begin
        if (m_arm) begin
          sat0 = (m_cnt > 64'd4194303) ? 64'd4194303 : m_cnt;
          sat4 = (m_cnt > 64'd15) ? 64'd15 : m_cnt;
          v0 = (sat0 >= longint'(frm_th));
          v1 = (sat4 >= longint'(frm_th4));
          q0.push_front(v0);
          if (q0.size() > HIST) void'(q0.pop_back());
          q1.push_front(v1);
          if (q1.size() > HIST) void'(q1.pop_back());
          m_votes0 = 0; foreach (q0[i]) m_votes0 += int'(q0[i]);
          m_votes4 = 0; foreach (q1[i]) m_votes4 += int'(q1[i]);
          m_rx0 = rx_next(m_votes0, m_rx0);
          m_rx4 = rx_next(m_votes4, m_rx4);
          m_valid = 1;
        end
        m_arm = 1;
        m_cnt = longint'(b);
      end else if (b) begin
        m_cnt++;
      end
      m_vsr = vs;
    end
  endtask

  task automatic step(input logic v, input logic d, input logic [23:0] w);
    vs = v; de = d; wd = w;
    @(posedge clk);
    model_update();
    #1;
    check("valid",  fv0,    m_valid);
    check("votes",  votes0, m_votes0);
    check("rx",     rx0,    m_rx0);
    check("valid4", fv4,    m_valid);
    check("votes4", votes4, m_votes4);
    check("rx4",    rx4,    m_rx4);
  endtask

  localparam logic [23:0] PX_BRIGHT = 24'hC8C8C8;
  localparam logic [23:0] PX_DIM_A  = 24'h643207;
  localparam logic [23:0] PX_DIM_B  = 24'h076432;

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 24'h0);
    rst = 1'b0;
  endtask

  // mode 0: all channels bright; mode 1: exactly one channel at 101
  task automatic send_pixels(input int nb, input int nd, input int mode);
    logic [23:0] p;
    for (int i = 0; i < nb; i++) begin
      p = (mode == 1) ? (24'd101 << (8 * (i % 3))) : PX_BRIGHT;
      step(1'b0, 1'b1, p);
    end
    for (int i = 0; i < nd; i++) step(1'b0, 1'b1, (i % 2) ? PX_DIM_B : PX_DIM_A);
    step(1'b0, 1'b0, 24'h0);
  endtask

  task automatic close_frame(input bit edge_px);
    step(1'b1, 1'b0, 24'h0);
    step(1'b1, 1'b0, 24'h0);
    step(1'b0, edge_px, PX_BRIGHT);
  endtask

  typedef struct {
    int nb; int nd; int mode; int th;
    bit ev; int evotes; bit erx;
  } frame_t;

  frame_t tbl[$];

  initial begin
    logic rv;
    rst = 1'b1; vs = 1'b0; de = 1'b0; wd = '0;
    px_th = 8'd100; frm_th = 22'd4; frm_th4 = 4'd15;

    tbl.push_back('{10, 0, 0, 4, 1'b0, 0, 1'b0});
    for (int i = 1; i <= 8; i++) tbl.push_back('{10, 0, 0, 4, 1'b1, i, (i >= 6)});
    for (int i = 7; i >= 2; i--) tbl.push_back('{0, 0, 0, 4, 1'b1, i, (i > 2)});
    tbl.push_back('{4, 5, 0, 4, 1'b1, 2, 1'b0});
    tbl.push_back('{3, 5, 0, 4, 1'b1, 1, 1'b0});
    tbl.push_back('{4, 0, 1, 4, 1'b1, 2, 1'b0});
    tbl.push_back('{0, 10, 0, 4, 1'b1, 2, 1'b0});
    tbl.push_back('{0, 0, 0, 0, 1'b1, 3, 1'b0});

    do_reset();
    check("reset_rx", rx0, 0);
    check("reset_votes", votes0, 0);
    check("reset_valid", fv0, 0);

    foreach (tbl[k]) begin
      frm_th = 22'(tbl[k].th);
      send_pixels(tbl[k].nb, tbl[k].nd, tbl[k].mode);
      close_frame(1'b0);
      check($sformatf("tbl%0d_valid", k), fv0, tbl[k].ev);
      check($sformatf("tbl%0d_votes", k), votes0, tbl[k].evotes);
      check($sformatf("tbl%0d_rx", k), rx0, tbl[k].erx);
      step(1'b0, 1'b0, 24'h0);
      check($sformatf("tbl%0d_pulse_end", k), fv0, 0);
    end

    // Bright pixel on the edge cycle counts toward the new frame.
    frm_th = 22'd4;
    do_reset();
    send_pixels(0, 0, 0); close_frame(1'b0);
    send_pixels(0, 0, 0); close_frame(1'b1);
    check("edge_px_dark", votes0, 0);
    send_pixels(3, 0, 0); close_frame(1'b0);
    check("edge_px_bright", votes0, 1);
    send_pixels(3, 0, 0); close_frame(1'b0);
    check("three_px_dark", votes0, 1);

    // Saturation on the narrow-counter instance.
    do_reset();
    frm_th4 = 4'd15;
    send_pixels(3, 0, 0); close_frame(1'b0);
    send_pixels(20, 0, 0); close_frame(1'b0);
    check("sat20_votes4", votes4, 1);
    send_pixels(15, 0, 0); close_frame(1'b0);
    check("sat15_votes4", votes4, 2);
    send_pixels(14, 0, 0); close_frame(1'b0);
    check("sat14_votes4", votes4, 2);
    frm_th4 = 4'd0;
    send_pixels(0, 0, 0); close_frame(1'b0);
    check("th0_votes4", votes4, 3);
    frm_th4 = 4'd15;

    // Reset mid-frame while inverting.
    do_reset();
    send_pixels(0, 0, 0); close_frame(1'b0);
    for (int i = 0; i < 7; i++) begin
      send_pixels(10, 0, 0); close_frame(1'b0);
    end
    check("pre_rst_votes", votes0, 7);
    check("pre_rst_rx", rx0, 1);
    send_pixels(5, 0, 0);
    rst = 1'b1;
    step(1'b0, 1'b1, PX_BRIGHT);
    rst = 1'b0;
    check("rst_mid_rx", rx0, 0);
    check("rst_mid_votes", votes0, 0);
    send_pixels(10, 0, 0); close_frame(1'b0);
    check("rst_first_edge", fv0, 0);
    send_pixels(10, 0, 0); close_frame(1'b0);
    check("rst_second_edge", fv0, 1);
    check("rst_second_votes", votes0, 1);

    // Reset coincident with an edge: nothing commits.
    step(1'b1, 1'b0, 24'h0);
    step(1'b1, 1'b0, 24'h0);
    rst = 1'b1;
    step(1'b0, 1'b0, 24'h0);
    rst = 1'b0;
    check("rst_edge_valid", fv0, 0);
    check("rst_edge_votes", votes0, 0);

    // Randomized phase.
    do_reset();
    rv = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 9) == 0) rv = ~rv;
      px_th   = 8'($urandom_range(95, 105));
      frm_th  = 22'($urandom_range(0, 10));
      frm_th4 = 4'($urandom_range(0, 15));
      step(rv, 1'($urandom_range(0, 1)),
           {8'($urandom_range(90, 110)), 8'($urandom_range(90, 110)), 8'($urandom_range(90, 110))});
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
